// File: rtl/wb_led_write_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_led_write_fifo_pkg
//  Description : Shared definitions for the Wishbone LED write buffer:
//                register offsets inside the window, STATUS/CTRL bit
//                positions, drain FSM state encoding and the STATUS packer.
//  Revision    : 1.0  initial release
// ============================================================================
package wb_led_write_fifo_pkg;

    // Register offsets relative to the window base (low address byte)
    localparam logic [7:0] c_OFF_DATA   = 8'h00;
    localparam logic [7:0] c_OFF_STATUS = 8'h04;
    localparam logic [7:0] c_OFF_CTRL   = 8'h08;

    // STATUS word layout
    localparam int unsigned c_STAT_EMPTY_BIT = 0;
    localparam int unsigned c_STAT_FULL_BIT  = 1;
    localparam int unsigned c_STAT_OVF_BIT   = 2;
    localparam int unsigned c_STAT_LEVEL_LSB = 8;

    // CTRL write bits
    localparam int unsigned c_CTRL_FLUSH_BIT   = 0;
    localparam int unsigned c_CTRL_CLR_OVF_BIT = 1;

    // Drain FSM states
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_PULSE = 2'd1;
    localparam logic [1:0] c_ST_WAIT  = 2'd2;

    function automatic logic [31:0] status_word(input logic [7:0] level,
                                                input logic       ovf,
                                                input logic       full,
                                                input logic       empty);
        logic [31:0] w;
        w                          = '0;
        w[c_STAT_LEVEL_LSB +: 8]   = level;
        w[c_STAT_OVF_BIT]          = ovf;
        w[c_STAT_FULL_BIT]         = full;
        w[c_STAT_EMPTY_BIT]        = empty;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_led_write_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_led_write_fifo_sync_fifo
//  Description : Registered synchronous FIFO (DEPTH x WIDTH). Flush has
//                priority over push and pop; pushes while full and pops
//                while empty are ignored. Head entry is visible on o_dout.
//  Ports       : clk, rst        clock, synchronous active-high reset
//                i_push/i_din    enqueue request and data
//                i_pop           dequeue request
//                i_flush         drop all entries
//                o_dout          head entry
//                o_full/o_empty  occupancy flags, o_level 0..DEPTH
//  Revision    : 1.0  initial release
// ============================================================================
module wb_led_write_fifo_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] c_FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == c_FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];

    // Fullness/emptiness are the pre-cycle values, so a push into a full
    // FIFO is dropped even if a pop happens in the same cycle.
    assign w_do_push = i_push && !o_full  && !i_flush;
    assign w_do_pop  = i_pop  && !o_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers are AW bits wide and DEPTH is a power of two, so they wrap.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_led_write_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_led_write_fifo
//  Description : Wishbone write buffer in front of the ws2812 driver. Bus
//                writes to DATA queue {led_num, rgb}; a paced drain FSM
//                pops one entry per write_o pulse while drain_ready_i is set.
//  Ports       : wb_clk_i/wb_rst_i   clock, synchronous active-high reset
//                wbs_*               Wishbone slave (one-cycle ack pulse)
//                drain_ready_i       consumer may accept an entry
//                led_num_o/rgb_data_o/write_o  registered driver interface
//                level_o             FIFO occupancy
//  Revision    : 1.0  initial release
// ============================================================================
module wb_led_write_fifo
    import wb_led_write_fifo_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned AW        = 3,
    parameter int unsigned GAP       = 2
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_i,
    input  logic          wbs_stb_i,
    input  logic          wbs_cyc_i,
    input  logic          wbs_we_i,
    input  logic [3:0]    wbs_sel_i,
    input  logic [31:0]   wbs_dat_i,
    input  logic [31:0]   wbs_adr_i,
    output logic          wbs_ack_o,
    output logic [31:0]   wbs_dat_o,
    input  logic          drain_ready_i,
    output logic [7:0]    led_num_o,
    output logic [23:0]   rgb_data_o,
    output logic          write_o,
    output logic [AW:0]   level_o
);

    // WAIT lasts GAP-1 cycles; together with the IDLE decision cycle this
    // leaves GAP idle cycles between pulses. GAP<=1 skips WAIT entirely.
    localparam int unsigned c_GCW      = (GAP > 2) ? $clog2(GAP) : 1;
    localparam logic [c_GCW-1:0] c_GAP_LOAD = c_GCW'((GAP >= 2) ? (GAP - 2) : 0);

    logic              r_ack;
    logic [31:0]       r_dat;
    logic              r_ovf;
    logic [1:0]        r_state;
    logic              r_write;
    logic [7:0]        r_led_num;
    logic [23:0]       r_rgb;
    logic [c_GCW-1:0]  r_gap_cnt;

    logic              w_accept;
    logic [7:0]        w_off;
    logic              w_push;
    logic              w_flush;
    logic              w_clr_ovf;
    logic              w_pop;
    logic [31:0]       w_rdata;
    logic [31:0]       w_head;
    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_level;

    // A request is taken only when ack is low, so a request held through
    // its ack cycle is accepted again as a new access on the next cycle.
    assign w_accept  = wbs_cyc_i && wbs_stb_i && !r_ack
                       && (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign w_off     = wbs_adr_i[7:0];
    assign w_push    = w_accept && wbs_we_i && (w_off == c_OFF_DATA) && (wbs_sel_i == 4'hF);
    assign w_flush   = w_accept && wbs_we_i && (w_off == c_OFF_CTRL)
                       && wbs_dat_i[c_CTRL_FLUSH_BIT];
    assign w_clr_ovf = w_accept && wbs_we_i && (w_off == c_OFF_CTRL)
                       && wbs_dat_i[c_CTRL_CLR_OVF_BIT];
    assign w_pop     = (r_state == c_ST_IDLE) && !w_empty && drain_ready_i && !w_flush;

    always_comb begin
        w_rdata = '0;
        if (w_accept && !wbs_we_i && (w_off == c_OFF_STATUS)) begin
            w_rdata = status_word(8'(w_level), r_ovf, w_full, w_empty);
        end
    end

    wb_led_write_fifo_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (32)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .i_push  (w_push),
        .i_din   (wbs_dat_i),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (w_level)
    );

    // Bus side: ack/read data registered, overflow flag sticky.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_ack <= w_accept;
            r_dat <= w_rdata;
            if (w_clr_ovf) begin
                r_ovf <= 1'b0;
            end else if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    // Drain FSM with registered driver outputs.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= c_ST_IDLE;
            r_write   <= 1'b0;
            r_led_num <= '0;
            r_rgb     <= '0;
            r_gap_cnt <= '0;
        end else if (w_flush) begin
            r_state   <= c_ST_IDLE;
            r_write   <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            r_write <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_pop) begin
                        r_led_num <= w_head[31:24];
                        r_rgb     <= w_head[23:0];
                        r_write   <= 1'b1;
                        r_state   <= c_ST_PULSE;
                    end
                end
                c_ST_PULSE: begin
                    if (GAP <= 1) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= c_GAP_LOAD;
                        r_state   <= c_ST_WAIT;
                    end
                end
                c_ST_WAIT: begin
                    if (r_gap_cnt == '0) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 1'b1;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    assign wbs_ack_o  = r_ack;
    assign wbs_dat_o  = r_dat;
    assign write_o    = r_write;
    assign led_num_o  = r_led_num;
    assign rgb_data_o = r_rgb;
    assign level_o    = w_level;

endmodule
`default_nettype wire
